pooling_layer_controller: RTL and testbench

Sequencer for the max-pooling stage. It walks the convolution output map in raster order, one KERNEL_SIZE×KERNEL_SIZE window at a time, and issues feature-buffer reads. It drives `input_valid`/`block_idx` of the pooling input interface (2-entry load/shift buffer) and tells the max unit when to clear, accumulate and emit. It holds no data path: control, counters and a downstream valid/ready handshake only.

---
 rtl/pooling_pkg.sv | 21 ++
 rtl/pooling_layer_controller_counter.sv | 89 ++++++++
 rtl/pooling_layer_controller.sv | 152 +++++++++++++++
 tb/tb_pooling_layer_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// Shared constants and FSM state encoding for the max-pooling controller
// and the pooling input interface.
package pooling_pkg;

  localparam int KERNEL_SIZE = 2;
  localparam int INPUT_SIZE  = 6;
  localparam int OUTPUT_SIZE = INPUT_SIZE / KERNEL_SIZE;
  localparam int ROW_WIDTH   = (OUTPUT_SIZE > 2) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int ADDR_WIDTH  = (INPUT_SIZE > 2) ? $clog2(INPUT_SIZE) : 1;
  localparam int KIDX_WIDTH  = (KERNEL_SIZE > 2) ? $clog2(KERNEL_SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    EMIT  = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/pooling_layer_controller_counter.sv
// Nested window counters (shift index, kernel row, output column, output row).
// Exposes next-cycle values so the controller can register its outputs.
module pool_window_counter
  import pooling_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_k_inc,
  input  logic                  i_kr_inc,
  input  logic                  i_kr_clr,
  input  logic                  i_c_inc,
  input  logic                  i_c_clr,
  input  logic                  i_r_inc,
  output logic [KIDX_WIDTH-1:0] o_k_nxt,
  output logic [KIDX_WIDTH-1:0] o_kr_nxt,
  output logic [ROW_WIDTH-1:0]  o_c_nxt,
  output logic [ROW_WIDTH-1:0]  o_r_nxt,
  output logic                  o_k_last,
  output logic                  o_kr_last,
  output logic                  o_c_last,
  output logic                  o_r_last
);

  logic [KIDX_WIDTH-1:0] r_k;
  logic [KIDX_WIDTH-1:0] r_kr;
  logic [ROW_WIDTH-1:0]  r_c;
  logic [ROW_WIDTH-1:0]  r_r;

  assign o_k_last  = (r_k  == KIDX_WIDTH'(KERNEL_SIZE - 1));
  assign o_kr_last = (r_kr == KIDX_WIDTH'(KERNEL_SIZE - 1));
  assign o_c_last  = (r_c  == ROW_WIDTH'(OUTPUT_SIZE - 1));
  assign o_r_last  = (r_r  == ROW_WIDTH'(OUTPUT_SIZE - 1));

  // Next-value decode; the shift index wraps on its own at the end of a row
  always_comb begin
    o_k_nxt  = r_k;
    o_kr_nxt = r_kr;
    o_c_nxt  = r_c;
    o_r_nxt  = r_r;
    if (i_clr) begin
      o_k_nxt  = {KIDX_WIDTH{1'b0}};
      o_kr_nxt = {KIDX_WIDTH{1'b0}};
      o_c_nxt  = {ROW_WIDTH{1'b0}};
      o_r_nxt  = {ROW_WIDTH{1'b0}};
    end else begin
      if (i_k_inc) begin
        o_k_nxt = o_k_last ? {KIDX_WIDTH{1'b0}} : r_k + KIDX_WIDTH'(1);
      end else begin
        o_k_nxt = r_k;
      end
      if (i_kr_clr) begin
        o_kr_nxt = {KIDX_WIDTH{1'b0}};
      end else if (i_kr_inc) begin
        o_kr_nxt = r_kr + KIDX_WIDTH'(1);
      end else begin
        o_kr_nxt = r_kr;
      end
      if (i_c_clr) begin
        o_c_nxt = {ROW_WIDTH{1'b0}};
      end else if (i_c_inc) begin
        o_c_nxt = r_c + ROW_WIDTH'(1);
      end else begin
        o_c_nxt = r_c;
      end
      if (i_r_inc) begin
        o_r_nxt = r_r + ROW_WIDTH'(1);
      end else begin
        o_r_nxt = r_r;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k  <= {KIDX_WIDTH{1'b0}};
      r_kr <= {KIDX_WIDTH{1'b0}};
      r_c  <= {ROW_WIDTH{1'b0}};
      r_r  <= {ROW_WIDTH{1'b0}};
    end else begin
      r_k  <= o_k_nxt;
      r_kr <= o_kr_nxt;
      r_c  <= o_c_nxt;
      r_r  <= o_r_nxt;
    end
  end

endmodule

// File: rtl/pooling_layer_controller.sv
// Max-pooling sequencer: walks the map window by window, issues buffer reads,
// steers the load/shift interface and the max unit, and hands results downstream.
module pooling_layer_controller
  import pooling_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_row,
  output logic [ADDR_WIDTH-1:0] rd_col,
  output logic                  iface_valid,
  output logic [ROW_WIDTH-1:0]  block_idx,
  output logic                  pool_en,
  output logic                  pool_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROW_WIDTH-1:0]  out_row,
  output logic [ROW_WIDTH-1:0]  out_col
);

  state_e r_state;
  state_e w_state_nxt;

  logic w_clr, w_k_inc, w_kr_inc, w_kr_clr, w_c_inc, w_c_clr, w_r_inc;
  logic w_k_last, w_kr_last, w_c_last, w_r_last;
  logic [KIDX_WIDTH-1:0] w_k_nxt, w_kr_nxt;
  logic [ROW_WIDTH-1:0]  w_c_nxt, w_r_nxt;

  pool_window_counter u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_k_inc   (w_k_inc),
    .i_kr_inc  (w_kr_inc),
    .i_kr_clr  (w_kr_clr),
    .i_c_inc   (w_c_inc),
    .i_c_clr   (w_c_clr),
    .i_r_inc   (w_r_inc),
    .o_k_nxt   (w_k_nxt),
    .o_kr_nxt  (w_kr_nxt),
    .o_c_nxt   (w_c_nxt),
    .o_r_nxt   (w_r_nxt),
    .o_k_last  (w_k_last),
    .o_kr_last (w_kr_last),
    .o_c_last  (w_c_last),
    .o_r_last  (w_r_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and counter control
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_k_inc     = 1'b0;
    w_kr_inc    = 1'b0;
    w_kr_clr    = 1'b0;
    w_c_inc     = 1'b0;
    w_c_clr     = 1'b0;
    w_r_inc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clr       = 1'b1;
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ:  w_state_nxt = LOAD;
      LOAD: w_state_nxt = SHIFT;
      SHIFT: begin
        w_k_inc = 1'b1;
        if (w_k_last) begin
          if (!w_kr_last) begin
            w_kr_inc    = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_state_nxt = EMIT;
          end
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      EMIT: begin
        // Downstream backpressure freezes everything, counters included
        if (out_ready) begin
          w_kr_clr = 1'b1;
          if (!w_c_last) begin
            w_c_inc     = 1'b1;
            w_state_nxt = REQ;
          end else if (!w_r_last) begin
            w_c_clr     = 1'b1;
            w_r_inc     = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_state_nxt = EMIT;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs registered from next state and next counter values, so they line up with r_state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      rd_row      <= {ADDR_WIDTH{1'b0}};
      rd_col      <= {ADDR_WIDTH{1'b0}};
      iface_valid <= 1'b0;
      block_idx   <= {ROW_WIDTH{1'b0}};
      pool_en     <= 1'b0;
      pool_first  <= 1'b0;
      out_valid   <= 1'b0;
      out_row     <= {ROW_WIDTH{1'b0}};
      out_col     <= {ROW_WIDTH{1'b0}};
    end else begin
      busy        <= (w_state_nxt != IDLE);
      done        <= (w_state_nxt == DONE);
      rd_en       <= (w_state_nxt == REQ);
      iface_valid <= (w_state_nxt == LOAD);
      pool_en     <= (w_state_nxt == SHIFT);
      pool_first  <= (w_state_nxt == SHIFT) && (w_kr_nxt == {KIDX_WIDTH{1'b0}})
                     && (w_k_nxt == {KIDX_WIDTH{1'b0}});
      out_valid   <= (w_state_nxt == EMIT);
      block_idx   <= w_r_nxt;
      out_row     <= w_r_nxt;
      out_col     <= w_c_nxt;
      if (w_state_nxt == REQ) begin
        rd_row <= ADDR_WIDTH'(w_r_nxt) * ADDR_WIDTH'(KERNEL_SIZE) + ADDR_WIDTH'(w_kr_nxt);
        rd_col <= ADDR_WIDTH'(w_c_nxt) * ADDR_WIDTH'(KERNEL_SIZE);
      end
    end
  end

endmodule

// File: tb/tb_pooling_layer_controller.sv
// Scenario bench for the pooling controller: scoreboard of expected reads and
// results filled at start, drained as the controller produces them.
module tb_pooling_layer_controller;
  import pooling_pkg::*;

  logic clk = 1'b0;
  logic rst_n, start, out_ready;
  logic busy, done, rd_en, iface_valid, pool_en, pool_first, out_valid;
  logic [ADDR_WIDTH-1:0] rd_row, rd_col;
  logic [ROW_WIDTH-1:0]  block_idx, out_row, out_col;

  int total = 0;
  int bad   = 0;

  logic [2*ADDR_WIDTH-1:0] exp_rd_q[$];
  logic [2*ROW_WIDTH-1:0]  exp_res_q[$];

  pooling_layer_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .iface_valid(iface_valid),
    .block_idx(block_idx), .pool_en(pool_en), .pool_first(pool_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  // Pulse start across one rising edge (edge 0); returns at the falling edge of cycle 1
  task automatic start_map();
    logic [ADDR_WIDTH-1:0] er, ec;
    logic [ROW_WIDTH-1:0]  orr, occ;
    exp_rd_q.delete();
    exp_res_q.delete();
    for (int r = 0; r < OUTPUT_SIZE; r++) begin
      for (int c = 0; c < OUTPUT_SIZE; c++) begin
        for (int kr = 0; kr < KERNEL_SIZE; kr++) begin
          er = ADDR_WIDTH'(r * KERNEL_SIZE + kr);
          ec = ADDR_WIDTH'(c * KERNEL_SIZE);
          exp_rd_q.push_back({er, ec});
        end
        orr = ROW_WIDTH'(r);
        occ = ROW_WIDTH'(c);
        exp_res_q.push_back({orr, occ});
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, rd_en, rd_row, rd_col, iface_valid, block_idx, pool_en,
         pool_first, out_valid, out_row, out_col} !== '0)
      begin bad++; $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b row=%0d col=%0d iv=%b bi=%0d pe=%b pf=%b ov=%b or=%0d oc=%0d, required all 0",
        busy, done, rd_en, rd_row, rd_col, iface_valid, block_idx, pool_en, pool_first, out_valid, out_row, out_col); end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || rd_en !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL idle_quiet: busy/rd_en seen high=%b, required 0", seen); end
  endtask

  task automatic test_first_window();
    logic [4:0] exp_ctl;
    logic [2*ADDR_WIDTH-1:0] e_rd;
    logic [2*ROW_WIDTH-1:0]  e_res;
    bit found;
    out_ready = 1'b1;
    start_map();
    for (int cy = 1; cy <= 9; cy++) begin
      exp_ctl = {(cy == 1 || cy == 5), (cy == 2 || cy == 6),
                 (cy == 3 || cy == 4 || cy == 7 || cy == 8), (cy == 3), (cy == 9)};
      total++;
      if ({rd_en, iface_valid, pool_en, pool_first, out_valid} !== exp_ctl)
        begin bad++; $display("FAIL window_ctl cycle %0d: got {rd,iv,pe,pf,ov}=%b, required %b",
          cy, {rd_en, iface_valid, pool_en, pool_first, out_valid}, exp_ctl); end
      if (rd_en === 1'b1 && exp_rd_q.size() > 0) begin
        e_rd = exp_rd_q.pop_front();
        total++;
        if ({rd_row, rd_col} !== e_rd) begin bad++; $display("FAIL window_rd cycle %0d: got row=%0d col=%0d, required row=%0d col=%0d",
          cy, rd_row, rd_col, e_rd[2*ADDR_WIDTH-1:ADDR_WIDTH], e_rd[ADDR_WIDTH-1:0]); end
      end
      if (out_valid === 1'b1 && exp_res_q.size() > 0) begin
        e_res = exp_res_q.pop_front();
        total++;
        if ({out_row, out_col} !== e_res) begin bad++; $display("FAIL window_res: got (%0d,%0d), required (%0d,%0d)",
          out_row, out_col, e_res[2*ROW_WIDTH-1:ROW_WIDTH], e_res[ROW_WIDTH-1:0]); end
      end
      @(negedge clk);
    end
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (done === 1'b1) found = 1'b1;
      @(negedge clk);
    end
    total++;
    if (found !== 1'b1) begin bad++; $display("FAIL window_drain: done seen=%b, required 1", found); end
  endtask

  task automatic test_full_map();
    int done_cnt, done_cyc, busy_bad;
    logic [2*ADDR_WIDTH-1:0] e_rd;
    logic [2*ROW_WIDTH-1:0]  e_res;
    out_ready = 1'b1;
    done_cnt = 0; done_cyc = 0; busy_bad = 0;
    start_map();
    for (int cy = 1; cy <= 90; cy++) begin
      if (rd_en === 1'b1) begin
        total++;
        if (exp_rd_q.size() == 0) begin bad++; $display("FAIL map_rd cycle %0d: unexpected read row=%0d col=%0d, required none", cy, rd_row, rd_col); end
        else begin
          e_rd = exp_rd_q.pop_front();
          if ({rd_row, rd_col} !== e_rd) begin bad++; $display("FAIL map_rd cycle %0d: got row=%0d col=%0d, required row=%0d col=%0d",
            cy, rd_row, rd_col, e_rd[2*ADDR_WIDTH-1:ADDR_WIDTH], e_rd[ADDR_WIDTH-1:0]); end
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        total++;
        if (exp_res_q.size() == 0) begin bad++; $display("FAIL map_res cycle %0d: unexpected result (%0d,%0d), required none", cy, out_row, out_col); end
        else begin
          e_res = exp_res_q.pop_front();
          if ({out_row, out_col} !== e_res) begin bad++; $display("FAIL map_res cycle %0d: got (%0d,%0d), required (%0d,%0d)",
            cy, out_row, out_col, e_res[2*ROW_WIDTH-1:ROW_WIDTH], e_res[ROW_WIDTH-1:0]); end
        end
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cy; end
      if (busy !== (cy <= 82)) busy_bad++;
      @(negedge clk);
    end
    total++;
    if (done_cnt != 1 || done_cyc != 82) begin bad++; $display("FAIL map_done: count=%0d last cycle=%0d, required count=1 cycle=82", done_cnt, done_cyc); end
    total++;
    if (busy_bad != 0) begin bad++; $display("FAIL map_busy: %0d wrong cycles, required 0", busy_bad); end
    total++;
    if (exp_rd_q.size() != 0 || exp_res_q.size() != 0) begin bad++; $display("FAIL map_left: reads=%0d results=%0d outstanding, required 0",
      exp_rd_q.size(), exp_res_q.size()); end
  endtask

  task automatic test_stall();
    int rd_bad;
    bit found;
    out_ready = 1'b0;
    start_map();
    repeat (8) @(negedge clk);
    rd_bad = 0;
    for (int cy = 9; cy <= 14; cy++) begin
      total++;
      if ({out_valid, out_row, out_col} !== {1'b1, {ROW_WIDTH{1'b0}}, {ROW_WIDTH{1'b0}}})
        begin bad++; $display("FAIL stall_hold cycle %0d: ov=%b (%0d,%0d), required ov=1 (0,0)", cy, out_valid, out_row, out_col); end
      if (rd_en !== 1'b0) rd_bad++;
      if (cy == 14) out_ready = 1'b1;
      @(negedge clk);
    end
    total++;
    if (rd_bad != 0) begin bad++; $display("FAIL stall_reads: %0d reads during stall, required 0", rd_bad); end
    total++;
    if ({rd_en, rd_row, rd_col} !== {1'b1, 3'd0, 3'd2})
      begin bad++; $display("FAIL stall_resume: rd_en=%b row=%0d col=%0d, required rd_en=1 row=0 col=2", rd_en, rd_row, rd_col); end
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (done === 1'b1) found = 1'b1;
      @(negedge clk);
    end
    total++;
    if (found !== 1'b1) begin bad++; $display("FAIL stall_drain: done seen=%b, required 1", found); end
  endtask

  task automatic test_reset_abort();
    bit stale;
    int done_cyc;
    logic [2*ADDR_WIDTH-1:0] e_rd;
    out_ready = 1'b1;
    stale = 1'b0;
    start_map();
    for (int cy = 1; cy < 20; cy++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, rd_en, rd_row, rd_col, iface_valid, block_idx, pool_en,
         pool_first, out_valid, out_row, out_col} !== '0)
      begin bad++; $display("FAIL abort_outputs: busy=%b rd_en=%b row=%0d col=%0d pe=%b ov=%b bi=%0d, required all 0",
        busy, rd_en, rd_row, rd_col, pool_en, out_valid, block_idx); end
    rst_n = 1'b1;
    repeat (10) begin
      if (done !== 1'b0 || busy !== 1'b0) stale = 1'b1;
      @(negedge clk);
    end
    total++;
    if (stale !== 1'b0) begin bad++; $display("FAIL abort_quiet: done/busy seen=%b, required 0", stale); end
    start_map();
    e_rd = exp_rd_q.pop_front();
    total++;
    if ({rd_en, rd_row, rd_col} !== {1'b1, e_rd})
      begin bad++; $display("FAIL abort_restart: rd_en=%b row=%0d col=%0d, required rd_en=1 row=0 col=0", rd_en, rd_row, rd_col); end
    done_cyc = 0;
    for (int cy = 1; cy <= 90; cy++) begin
      if (done === 1'b1) done_cyc = cy;
      @(negedge clk);
    end
    total++;
    if (done_cyc != 82) begin bad++; $display("FAIL abort_rerun_done: done at cycle %0d, required 82", done_cyc); end
  endtask

  task automatic test_start_ignored();
    int rd_cnt, done_cnt, late_busy;
    out_ready = 1'b1;
    rd_cnt = 0; done_cnt = 0; late_busy = 0;
    start_map();
    for (int cy = 1; cy <= 95; cy++) begin
      if (rd_en === 1'b1) rd_cnt++;
      if (done === 1'b1) done_cnt++;
      if (cy >= 83 && busy !== 1'b0) late_busy++;
      start = (cy == 30 || cy == 82);
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (rd_cnt != 2 * KERNEL_SIZE * OUTPUT_SIZE * OUTPUT_SIZE / 2)
      begin bad++; $display("FAIL ignore_reads: %0d reads, required %0d", rd_cnt, KERNEL_SIZE * OUTPUT_SIZE * OUTPUT_SIZE); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL ignore_done: %0d done pulses, required 1", done_cnt); end
    total++;
    if (late_busy != 0) begin bad++; $display("FAIL ignore_restart: busy in %0d cycles after done, required 0", late_busy); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_first_window();
    @(negedge clk);
    test_full_map();
    test_stall();
    @(negedge clk);
    test_reset_abort();
    @(negedge clk);
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
